// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl
//   Command sequencer between UART_RX, REG_FILE and UART_TX. Byte frames from
//   the receiver are parsed into register-file transactions:
//     WR_CMD, address, data  -> one-cycle WrEn with Address/WrData
//     RD_CMD, address        -> one-cycle RdEn, wait for Rd_VLD, send RdData
//   Read data is handed to the transmitter with a one-cycle TX_D_VLD once
//   TX_BUSY is low. Unknown commands and read timeouts pulse ERR.
//
// Ports
//   CLK, RST            clock; synchronous active-high reset
//   RX_P_DATA, RX_D_VLD received byte and its one-cycle valid strobe
//   RdData, Rd_VLD      register-file read data and read-valid strobe
//   TX_BUSY             transmitter busy
//   WrEn, RdEn          register-file write / read enables (one cycle each)
//   Address, WrData     register-file address and write data
//   TX_P_DATA, TX_D_VLD byte to transmit and its one-cycle valid strobe
//   ERR                 one-cycle pulse on unknown command or read timeout
module reg_file_ctrl #(
  parameter int unsigned              DATA_WIDTH = 8,
  parameter int unsigned              ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0]    WR_CMD     = 8'hAA,
  parameter logic [DATA_WIDTH-1:0]    RD_CMD     = 8'hBB,
  parameter int unsigned              RD_TIMEOUT = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  Rd_VLD,
  input  logic                  TX_BUSY,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  ERR
);

  localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(RD_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_EXEC,
    RD_ADDR,
    RD_EXEC,
    RD_WAIT,
    TX_SEND
  } state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  wren_n, rden_n, txvld_n, err_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wrdata_n, txdata_n;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      TX_D_VLD  <= 1'b0;
      ERR       <= 1'b0;
      Address   <= '0;
      WrData    <= '0;
      TX_P_DATA <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      WrEn      <= wren_n;
      RdEn      <= rden_n;
      TX_D_VLD  <= txvld_n;
      ERR       <= err_n;
      Address   <= addr_n;
      WrData    <= wrdata_n;
      TX_P_DATA <= txdata_n;
    end
  end

  // Next-state and next-output logic. Strobes default low so every pulse
  // lasts exactly one cycle; data registers default to holding.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    wren_n   = 1'b0;
    rden_n   = 1'b0;
    txvld_n  = 1'b0;
    err_n    = 1'b0;
    addr_n   = Address;
    wrdata_n = WrData;
    txdata_n = TX_P_DATA;

    case (state)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_CMD)      state_n = WR_ADDR;
          else if (RX_P_DATA == RD_CMD) state_n = RD_ADDR;
          else                          err_n   = 1'b1;
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_n  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_n = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wrdata_n = RX_P_DATA;
          wren_n   = 1'b1;
          state_n  = WR_EXEC;
        end
      end
      WR_EXEC: begin
        state_n = IDLE;
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_n  = RX_P_DATA[ADDR_WIDTH-1:0];
          rden_n  = 1'b1;
          state_n = RD_EXEC;
        end
      end
      RD_EXEC: begin
        cnt_n = '0;
        // A register file that answers in the RdEn cycle skips RD_WAIT.
        if (Rd_VLD) begin
          txdata_n = RdData;
          state_n  = TX_SEND;
        end else begin
          state_n  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (Rd_VLD) begin
          txdata_n = RdData;
          state_n  = TX_SEND;
        end else if (cnt + CNT_W'(1) == TIMEOUT_C) begin
          // RD_TIMEOUT cycles spent here without Rd_VLD: give up.
          cnt_n   = '0;
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      TX_SEND: begin
        if (!TX_BUSY) begin
          txvld_n = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// tb_reg_file_ctrl
//   Directed bench for reg_file_ctrl: write, read, busy hold, unknown command,
//   read timeout and mid-transaction reset. A small register-file model
//   answers RdEn with Rd_VLD one cycle later (when enabled).
`timescale 1ns/1ps
module tb_reg_file_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_p_data;
  logic       rx_d_vld;
  logic [7:0] rd_data;
  logic       rd_vld;
  logic       tx_busy;
  logic       wr_en;
  logic       rd_en;
  logic [3:0] address;
  logic [7:0] wr_data;
  logic [7:0] tx_p_data;
  logic       tx_d_vld;
  logic       err;

  logic       rf_en;
  logic [7:0] mem [16];

  int checks = 0;
  int passes = 0;

  // Pulse counters sampled mid-cycle.
  int wr_pulses = 0, rd_pulses = 0, tx_pulses = 0, err_pulses = 0, both_hi = 0;

  always #5 clk = ~clk;

  reg_file_ctrl #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .WR_CMD    (8'hAA),
    .RD_CMD    (8'hBB),
    .RD_TIMEOUT(15)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .RX_P_DATA(rx_p_data),
    .RX_D_VLD (rx_d_vld),
    .RdData   (rd_data),
    .Rd_VLD   (rd_vld),
    .TX_BUSY  (tx_busy),
    .WrEn     (wr_en),
    .RdEn     (rd_en),
    .Address  (address),
    .WrData   (wr_data),
    .TX_P_DATA(tx_p_data),
    .TX_D_VLD (tx_d_vld),
    .ERR      (err)
  );

  // Register-file model.
  always @(posedge clk) begin
    rd_vld  <= rf_en & rd_en;
    rd_data <= mem[address];
    if (wr_en) mem[address] <= wr_data;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en)          wr_pulses++;
      if (rd_en)          rd_pulses++;
      if (tx_d_vld)       tx_pulses++;
      if (err)            err_pulses++;
      if (wr_en && rd_en) both_hi++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      passes++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_p_data = b;
    rx_d_vld  = 1'b1;
    step();
    rx_d_vld  = 1'b0;
  endtask

  initial begin
    int wr0, rd0, tx0, err0;
    int seen_tx, seen_err;

    rst = 1'b1; rx_p_data = 8'h00; rx_d_vld = 1'b0; tx_busy = 1'b0; rf_en = 1'b1;
    step(); step();
    check("rst_wren",   {31'd0, wr_en},    32'd0);
    check("rst_rden",   {31'd0, rd_en},    32'd0);
    check("rst_err",    {31'd0, err},      32'd0);
    check("rst_txvld",  {31'd0, tx_d_vld}, 32'd0);
    rst = 1'b0;
    step();

    // Write 0x3C to address 5 (upper address bits ignored via 0x05 anyway).
    wr0 = wr_pulses; rd0 = rd_pulses; err0 = err_pulses;
    send(8'hAA); send(8'h05);
    check("wr_early_wren", {31'd0, wr_en}, 32'd0);
    send(8'h3C);
    check("wr_wren",    {31'd0, wr_en}, 32'd1);
    check("wr_addr",    {28'd0, address}, 32'd5);
    check("wr_data",    {24'd0, wr_data}, 32'h3C);
    step();
    check("wr_wren_off", {31'd0, wr_en}, 32'd0);

    // Read back address 5; command arrives in the cycle the FSM is back in IDLE.
    send(8'hBB); send(8'h05);
    check("rd_rden",    {31'd0, rd_en}, 32'd1);
    check("rd_addr",    {28'd0, address}, 32'd5);
    step();
    check("rd_rden_off", {31'd0, rd_en}, 32'd0);
    step();
    check("rd_tx_early", {31'd0, tx_d_vld}, 32'd0);
    step();
    check("rd_txvld",   {31'd0, tx_d_vld}, 32'd1);
    check("rd_txdata",  {24'd0, tx_p_data}, 32'h3C);
    step();
    check("rd_txvld_off", {31'd0, tx_d_vld}, 32'd0);
    check("wr_rd_pulses", wr_pulses - wr0, 32'd1);
    check("rd_rd_pulses", rd_pulses - rd0, 32'd1);
    check("wr_rd_no_err", err_pulses - err0, 32'd0);

    // Busy hold: TX_BUSY high for 10 cycles after Rd_VLD; stray frames ignored.
    tx_busy = 1'b1;
    wr0 = wr_pulses; rd0 = rd_pulses; tx0 = tx_pulses; err0 = err_pulses;
    send(8'hBB); send(8'h05);
    step();                       // RD_WAIT with Rd_VLD high
    seen_tx = 0; seen_err = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2)      send(8'hAA);
      else if (i == 5) send(8'h11);
      else if (i == 7) send(8'h03);
      else             step();
      if (tx_d_vld) seen_tx++;
      if (err)      seen_err++;
    end
    check("busy_no_tx",  seen_tx,  32'd0);
    check("busy_no_err", seen_err, 32'd0);
    tx_busy = 1'b0;
    step();
    check("busy_txvld",  {31'd0, tx_d_vld}, 32'd1);
    check("busy_txdata", {24'd0, tx_p_data}, 32'h3C);
    step();
    check("busy_txvld_off", {31'd0, tx_d_vld}, 32'd0);
    check("busy_wr_pulses", wr_pulses - wr0, 32'd0);
    check("busy_rd_pulses", rd_pulses - rd0, 32'd1);
    check("busy_tx_pulses", tx_pulses - tx0, 32'd1);
    check("busy_err_pulses", err_pulses - err0, 32'd0);

    // Unknown command, then write 0xFF to address 15.
    wr0 = wr_pulses; rd0 = rd_pulses;
    send(8'h11);
    check("unk_err",    {31'd0, err}, 32'd1);
    step();
    check("unk_err_off", {31'd0, err}, 32'd0);
    check("unk_no_en",  (wr_pulses - wr0) + (rd_pulses - rd0), 32'd0);
    send(8'hAA); send(8'h0F); send(8'hFF);
    check("w15_wren",   {31'd0, wr_en}, 32'd1);
    check("w15_addr",   {28'd0, address}, 32'd15);
    check("w15_data",   {24'd0, wr_data}, 32'hFF);
    step();

    // Read timeout: no Rd_VLD; ERR 15 cycles after RD_WAIT entry.
    rf_en = 1'b0;
    tx0 = tx_pulses;
    send(8'hBB); send(8'h02);
    check("to_rden",    {31'd0, rd_en}, 32'd1);
    step();                       // first RD_WAIT cycle
    seen_err = 0;
    for (int i = 1; i < 15; i++) begin
      step();
      if (err) seen_err++;
    end
    check("to_no_early_err", seen_err, 32'd0);
    step();
    check("to_err",     {31'd0, err}, 32'd1);
    step();
    check("to_err_off", {31'd0, err}, 32'd0);
    check("to_no_tx",   tx_pulses - tx0, 32'd0);
    rf_en = 1'b1;

    // Reset mid-transaction.
    wr0 = wr_pulses;
    send(8'hAA); send(8'h07);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mr_wren",    {31'd0, wr_en}, 32'd0);
    check("mr_rden",    {31'd0, rd_en}, 32'd0);
    check("mr_addr",    {28'd0, address}, 32'd0);
    check("mr_wrdata",  {24'd0, wr_data}, 32'd0);
    check("mr_txdata",  {24'd0, tx_p_data}, 32'd0);
    check("mr_txvld",   {31'd0, tx_d_vld}, 32'd0);
    check("mr_err",     {31'd0, err}, 32'd0);
    send(8'h55);
    check("mr_55_err",  {31'd0, err}, 32'd1);
    step(); step();
    check("mr_no_wr",   wr_pulses - wr0, 32'd0);
    check("never_both", both_hi, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
